// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a valid/ready byte output.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial input line, idle high
//   data       received byte, stable while valid is high
//   valid      data holds an unconsumed byte
//   ready      consumer accepts data when valid && ready at a rising edge
//   busy       frame reception in progress
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte completed while the previous one was still held
//   clr_err    synchronous pulse clearing frame_err and overrun
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_meta_q, rx_sync_q;
  logic [2:0]      hist_q;
  logic            maj;
  logic            load, set_fe, set_ov;

  // Two-flop synchronizer followed by a 3-sample history for majority voting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      hist_q    <= 3'b111;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      hist_q    <= {hist_q[1:0], rx_sync_q};
    end
  end

  assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    set_fe  = 1'b0;
    set_ov  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          if (maj) begin
            state_d = StIdle;  // false start, no flag
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StData;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {maj, shift_q[7:1]};  // LSB arrives first
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (maj) begin
            // A byte accepted in this very cycle frees the slot for the new one.
            if (!valid_q || ready) load = 1'b1;
            else                   set_ov = 1'b1;
            state_d = StIdle;
          end else begin
            set_fe  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitIdle: begin
        // Hold off until the line is released so a break yields one error only.
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d      = load ? shift_q : data_q;
    valid_d     = load ? 1'b1 : ((valid_q && ready) ? 1'b0 : valid_q);
    frame_err_d = set_fe ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    overrun_d   = set_ov ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
